// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the M-stage data memory.
// Legal byte-lane patterns, trace record layout and lane merging.
package mips_mem_pkg;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_B0   = 4'b0001;
    localparam logic [3:0] BYTEEN_B1   = 4'b0010;
    localparam logic [3:0] BYTEEN_B2   = 4'b0100;
    localparam logic [3:0] BYTEEN_B3   = 4'b1000;
    localparam logic [3:0] BYTEEN_H0   = 4'b0011;
    localparam logic [3:0] BYTEEN_H1   = 4'b1100;
    localparam logic [3:0] BYTEEN_W    = 4'b1111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_rec_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic byteen_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BYTEEN_NONE, BYTEEN_B0, BYTEEN_B1, BYTEEN_B2,
            BYTEEN_B3, BYTEEN_H0, BYTEEN_H1, BYTEEN_W: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Store-trace FIFO: registered head, no fall-through.
// DEPTH must be a power of two so pointers wrap naturally.
module trace_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  trc_rec_t rec_i,
    input  logic     pop_i,
    output logic     valid_o,
    output logic     full_o,
    output trc_rec_t rec_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    trc_rec_t      mem_q [DEPTH];
    logic          do_push, do_pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign rec_o   = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) wp_d = wp_q + 1'b1;
        if (do_pop)  rp_d = rp_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem_q[wp_q] <= rec_i;
    end

endmodule

// File: rtl/dm_trace_mem.sv
// Byte-enabled M-stage data memory with clear sweep,
// fixed-latency responses and a store trace FIFO.
module dm_trace_mem
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE      = 32'h0,
    parameter int          RD_LAT    = 1,
    parameter int          TRC_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we;
    logic [31:0]       mem_q [DEPTH];

    logic              acc, err, st, trc_full;
    logic [31:0]       off, old_w, merged, rdata_cap;
    logic [ADDR_W-1:0] idx;
    trc_rec_t          push_rec, head_rec;

    logic              v_q [RD_LAT];
    logic [31:0]       d_q [RD_LAT];
    logic              e_q [RD_LAT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) state_d = RUN;
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == RUN) && !trc_full;
    assign acc       = req_valid && req_ready;
    assign off       = req_addr - BASE;
    assign idx       = off[ADDR_W+1:2];
    // Below-BASE addresses wrap to huge offsets and land in the error range.
    assign err       = ({1'b0, off} >= LIMIT) || !byteen_legal(req_byteen);
    assign old_w     = mem_q[idx];
    assign merged    = merge_bytes(old_w, req_wdata, req_byteen);
    assign st        = acc && !err && (req_byteen != BYTEEN_NONE);
    assign rdata_cap = err ? '0 : merged;

    always_ff @(posedge clk) begin
        if (reset && clr_we)  mem_q[cnt_q] <= '0;
        else if (reset && st) mem_q[idx]   <= merged;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
                e_q[i] <= 1'b0;
            end
        end else begin
            v_q[0] <= acc;
            d_q[0] <= acc ? rdata_cap : '0;
            e_q[0] <= acc && err;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
                e_q[i] <= e_q[i-1];
            end
        end
    end

    assign rsp_valid = v_q[RD_LAT-1];
    assign rsp_rdata = d_q[RD_LAT-1];
    assign rsp_err   = e_q[RD_LAT-1];

    assign push_rec = '{pc: req_pc,
                        addr: {req_addr[31:2], 2'b00},
                        data: merged};

    trace_fifo #(.DEPTH(TRC_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (st),
        .rec_i   (push_rec),
        .pop_i   (trc_ready),
        .valid_o (trc_valid),
        .full_o  (trc_full),
        .rec_o   (head_rec)
    );

    assign trc_pc   = head_rec.pc;
    assign trc_addr = head_rec.addr;
    assign trc_data = head_rec.data;

endmodule

// File: tb/tb_dm_trace_mem.sv
// Directed bench for dm_trace_mem: vector table plus
// hand-written pipelining, backpressure and reset sequences.
module tb_dm_trace_mem;

    localparam int RDL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_byteen = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [31:0] trc_pc, trc_addr, trc_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        push;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    vec_t tv [16];
    rec_t exq [$];

    dm_trace_mem #(
        .ADDR_W(4), .BASE(32'h0), .RD_LAT(RDL), .TRC_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_byteen(req_byteen),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .trc_valid(trc_valid), .trc_ready(trc_ready),
        .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] pc);
        req_valid  = 1'b1;
        req_addr   = a;
        req_byteen = be;
        req_wdata  = wd;
        req_pc     = pc;
    endtask

    // Called at a negedge; returns at posedge+1 after the accept.
    task automatic send(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 1);
        drive(a, be, wd, pc);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_byteen = '0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er);
        for (int i = 0; i < RDL - 1; i++) begin
            @(negedge clk);
            chk("rsp_early", {31'b0, rsp_valid}, 0);
        end
        @(negedge clk);
        chk("rsp_valid", {31'b0, rsp_valid}, 1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic drain();
        rec_t r;
        while (exq.size() > 0) begin
            r = exq.pop_front();
            chk("trc_valid", {31'b0, trc_valid}, 1);
            chk("trc_pc", trc_pc, r.pc);
            chk("trc_addr", trc_addr, r.addr);
            chk("trc_data", trc_data, r.data);
            trc_ready = 1'b1;
            @(posedge clk);
            #1 trc_ready = 1'b0;
            @(negedge clk);
        end
        chk("trc_empty", {31'b0, trc_valid}, 0);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        tv[0]  = '{32'h3C, 4'h0, 32'h0,        32'h0,   32'h0,        1'b0, 1'b0};
        tv[1]  = '{32'h10, 4'hF, 32'h12345678, 32'h100, 32'h12345678, 1'b0, 1'b1};
        tv[2]  = '{32'h11, 4'h2, 32'h0000AB00, 32'h104, 32'h1234AB78, 1'b0, 1'b1};
        tv[3]  = '{32'h10, 4'h0, 32'h0,        32'h0,   32'h1234AB78, 1'b0, 1'b0};
        tv[4]  = '{32'h40, 4'h0, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0};
        tv[5]  = '{32'h14, 4'h5, 32'hFFFFFFFF, 32'h0,   32'h0,        1'b1, 1'b0};
        tv[6]  = '{32'h14, 4'h0, 32'h0,        32'h0,   32'h0,        1'b0, 1'b0};
        tv[7]  = '{32'h16, 4'hC, 32'hBEEF0000, 32'h108, 32'hBEEF0000, 1'b0, 1'b1};
        tv[8]  = '{32'h14, 4'h1, 32'h000000CD, 32'h10C, 32'hBEEF00CD, 1'b0, 1'b1};
        tv[9]  = '{32'h17, 4'h8, 32'h11000000, 32'h110, 32'h11EF00CD, 1'b0, 1'b1};
        tv[10] = '{32'h18, 4'h3, 32'h00005A5A, 32'h114, 32'h00005A5A, 1'b0, 1'b1};
        tv[11] = '{32'hFFFFFFFC, 4'hF, 32'h1, 32'h0,   32'h0,        1'b1, 1'b0};
        tv[12] = '{32'h40, 4'hF, 32'h1,        32'h0,   32'h0,        1'b1, 1'b0};
        tv[13] = '{32'h17, 4'h0, 32'h0,        32'h0,   32'h11EF00CD, 1'b0, 1'b0};
        tv[14] = '{32'h3F, 4'h4, 32'h00770000, 32'h118, 32'h00770000, 1'b0, 1'b1};
        tv[15] = '{32'h3C, 4'h0, 32'h0,        32'h0,   32'h00770000, 1'b0, 1'b0};

        // Reset values, then the clear sweep.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 0);
        chk("rst_rspv", {31'b0, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", {31'b0, rsp_err}, 0);
        chk("rst_trcv", {31'b0, trc_valid}, 0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("sweep_ready", {31'b0, req_ready}, (i == 16) ? 1 : 0);
        end

        // Vector table, one request at a time.
        for (int i = 0; i < 16; i++) begin
            send(tv[i].addr, tv[i].be, tv[i].wd, tv[i].pc);
            wait_rsp(rd, er);
            chk("vec_rdata", rd, tv[i].exp_rd);
            chk("vec_err", {31'b0, er}, {31'b0, tv[i].exp_err});
            if (tv[i].push)
                exq.push_back('{tv[i].pc, tv[i].addr & 32'hFFFFFFFC,
                                tv[i].exp_rd});
        end
        drain();

        // Three back-to-back accepts, in-flight data must not change.
        drive(32'h20, 4'hF, 32'h0000AAA1, 32'h300);
        @(posedge clk);
        #1 drive(32'h20, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 drive(32'h22, 4'h1, 32'h000000B2, 32'h308);
        chk("pipe_early", {31'b0, rsp_valid}, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_byteen = '0;
        @(negedge clk);
        chk("pipe_v0", {31'b0, rsp_valid}, 1);
        chk("pipe_d0", rsp_rdata, 32'h0000AAA1);
        @(negedge clk);
        chk("pipe_v1", {31'b0, rsp_valid}, 1);
        chk("pipe_d1", rsp_rdata, 32'h0000AAA1);
        @(negedge clk);
        chk("pipe_v2", {31'b0, rsp_valid}, 1);
        chk("pipe_d2", rsp_rdata, 32'h0000AAB2);
        @(negedge clk);
        chk("pipe_idle", {31'b0, rsp_valid}, 0);
        exq.push_back('{32'h300, 32'h20, 32'h0000AAA1});
        exq.push_back('{32'h308, 32'h20, 32'h0000AAB2});
        drain();

        // Fill the trace FIFO; a pop frees ready one cycle later.
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", {31'b0, req_ready}, 1);
            drive(32'(i * 4), 4'hF, 32'hC0DE0000 | 32'(i), 32'(32'h200 + i * 4));
            @(posedge clk);
            #1 req_valid = 1'b0;
            req_byteen = '0;
            @(negedge clk);
        end
        chk("full_ready", {31'b0, req_ready}, 0);
        chk("full_head", trc_data, 32'hC0DE0000);
        chk("full_pc", trc_pc, 32'h200);
        trc_ready = 1'b1;
        chk("pop_ready", {31'b0, req_ready}, 0);
        @(posedge clk);
        #1 trc_ready = 1'b0;
        @(negedge clk);
        chk("after_pop", {31'b0, req_ready}, 1);
        chk("next_head", trc_data, 32'hC0DE0001);

        // Reset with two loads in flight.
        drive(32'h00, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 drive(32'h04, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            chk("rr_rspv", {31'b0, rsp_valid}, 0);
            chk("rr_trcv", {31'b0, trc_valid}, 0);
            chk("rr_ready", {31'b0, req_ready}, (i == 16) ? 1 : 0);
        end
        send(32'h00, 4'h0, 32'h0, 32'h0);
        wait_rsp(rd, er);
        chk("rr_clr0", rd, 0);
        send(32'h3C, 4'h0, 32'h0, 32'h0);
        wait_rsp(rd, er);
        chk("rr_clr3c", rd, 0);
        chk("rr_err", {31'b0, er}, 0);
        chk("rr_trc_end", {31'b0, trc_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
